// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared combinational 4-bit ALU.
// One operation in flight; result returned on a valid/ready channel tagged with the requester ID.
module alu_req_arbiter #(
  parameter int unsigned MUL_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_sel,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_sel,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_c,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] SEL_MUL    = 4'b0101;
  localparam logic [2:0] MUL_WAIT_L = 3'(MUL_WAIT);

  state_t     r_state;
  state_t     w_next;
  logic       r_rr;
  logic [2:0] r_cnt;
  logic       w_grant;
  logic       w_accept;
  logic       w_legal;
  logic [3:0] w_sel;
  logic [3:0] w_a;
  logic [3:0] w_b;

  // r_rr names the requester favoured when both are valid
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) w_grant = r_rr;
    else if (req1_valid)          w_grant = 1'b1;
    w_accept   = (r_state == IDLE) && (req0_valid || req1_valid);
    req0_ready = w_accept && !w_grant;
    req1_ready = w_accept && w_grant;
    w_sel      = w_grant ? req1_sel : req0_sel;
    w_a        = w_grant ? req1_a   : req0_a;
    w_b        = w_grant ? req1_b   : req0_b;
  end

  always_comb begin
    unique case (w_sel)
      4'b0000, 4'b1111, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b0101: w_legal = 1'b1;
      default:                                     w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_legal ? EXEC : RESP;
      EXEC:    if (r_cnt == '0) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      r_rr      <= 1'b0;
      r_cnt     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            alu_a   <= w_a;
            alu_b   <= w_b;
            alu_sel <= w_sel;
            rsp_id  <= w_grant;
            r_rr    <= ~w_grant;
            if (w_legal) begin
              r_cnt <= (w_sel == SEL_MUL) ? MUL_WAIT_L : '0;
            end else begin
              // Illegal opcodes skip the ALU and answer immediately
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            rsp_data  <= alu_c;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed scoreboard bench for alu_req_arbiter with a behavioural ALU model driving alu_c.
module tb_alu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_sel, req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_sel, req1_a, req1_b;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic [7:0] alu_c;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id, rsp_err, busy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       err;
  } rsp_t;
  rsp_t sb[$];

  always #5 clk = ~clk;

  alu_req_arbiter #(.MUL_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [7:0] alu_model(input logic [3:0] s, input logic [3:0] a,
                                           input logic [3:0] b);
    logic [7:0] ea, eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (s)
      4'b0000: return ea + eb;
      4'b1111: return ea - eb;
      4'b0001: return ea & eb;
      4'b0010: return ea | eb;
      4'b0100: return ea ^ eb;
      4'b1000: return {7'b0, a == b};
      4'b0011: return {7'b0, a > b};
      4'b0110: return ea << b;
      4'b1100: return ea >> b;
      4'b0101: return ea * eb;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_c = alu_model(alu_sel, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [7:0] data, input logic err);
    rsp_t e;
    e.id = id; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  // Called just before the acceptance edge; counts edges until rsp_valid.
  task automatic wait_rsp(input int lat, input logic [3:0] sel);
    int   n;
    rsp_t e;
    n = 0;
    do begin
      step();
      n++;
      if (!rsp_valid) begin
        chk("alu_sel_hold", 32'(alu_sel), 32'(sel));
        chk("ready_low_exec", 32'({req0_ready, req1_ready}), 0);
      end
    end while (!rsp_valid && n < 20);
    chk("latency", n, lat);
    if (rsp_valid) begin
      chk("ready_low_resp", 32'({req0_ready, req1_ready}), 0);
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_sel}), 0);
    chk({tag, "_rsp"}, 32'({rsp_valid, rsp_data, rsp_id, rsp_err}), 0);
  endtask

  logic [3:0] t_sel [5] = '{4'b1111, 4'b0110, 4'b1100, 4'b0011, 4'b0000};
  logic [3:0] t_a   [5] = '{4'h5, 4'h3, 4'hC, 4'h7, 4'hF};
  logic [3:0] t_b   [5] = '{4'h3, 4'h2, 4'h2, 4'h2, 4'hF};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_sel = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_sel = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1'b1;
    #1;
    chk_reset_outputs("reset");
    step();
    step();
    rst = 1'b0;

    // Single SUM from requester 0
    req0_valid = 1; req0_sel = 4'b0000; req0_a = 4'd9; req0_b = 4'd8;
    #1;
    chk("t1_ready", 32'({req0_ready, req1_ready}), 32'b10);
    push(1'b0, 8'h11, 1'b0);
    wait_rsp(2, 4'b0000);
    chk("t1_alu_ops", 32'({alu_a, alu_b}), 32'h98);
    req0_valid = 0;
    step();
    chk("t1_busy_low", 32'({busy, rsp_valid}), 0);

    // Alternating grants after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1; req0_sel = 4'b0001; req0_a = 4'hF; req0_b = 4'h3;
    req1_valid = 1; req1_sel = 4'b0010; req1_a = 4'h1; req1_b = 4'h2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_grant", 32'({req0_ready, req1_ready}), (i % 2 == 0) ? 32'b10 : 32'b01);
      push(1'((i % 2)), 8'h03, 1'b0);
      wait_rsp(2, (i % 2 == 0) ? 4'b0001 : 4'b0010);
      step();
      chk("t2_rsp_drop", 32'(rsp_valid), 0);
    end

    // Multiply with MUL_WAIT=3
    req1_valid = 0;
    req0_sel = 4'b0101; req0_a = 4'hF; req0_b = 4'hF;
    #1;
    chk("t3_ready", 32'({req0_ready, req1_ready}), 32'b10);
    push(1'b0, 8'hE1, 1'b0);
    wait_rsp(5, 4'b0101);
    req0_valid = 0;
    step();

    // Illegal opcode from requester 1
    req1_valid = 1; req1_sel = 4'b0111; req1_a = 4'h5; req1_b = 4'h6;
    #1;
    chk("t4_ready", 32'({req0_ready, req1_ready}), 32'b01);
    push(1'b1, 8'h00, 1'b1);
    wait_rsp(1, 4'b0111);
    chk("t4_alu_updated", 32'({alu_sel, alu_a, alu_b}), 32'h756);
    req1_valid = 0;
    step();

    // Assorted opcodes from requester 1
    for (int i = 0; i < 5; i++) begin
      req1_valid = 1; req1_sel = t_sel[i]; req1_a = t_a[i]; req1_b = t_b[i];
      #1;
      chk("t5_ready", 32'(req1_ready), 1);
      push(1'b1, alu_model(t_sel[i], t_a[i], t_b[i]), 1'b0);
      wait_rsp(2, t_sel[i]);
      req1_valid = 0;
      step();
      chk("t5_idle", 32'(busy), 0);
    end

    // Backpressure with both requesters pending
    rsp_ready = 0;
    req0_valid = 1; req0_sel = 4'b0100; req0_a = 4'hA; req0_b = 4'h5;
    req1_valid = 1; req1_sel = 4'b1000; req1_a = 4'h3; req1_b = 4'h3;
    #1;
    chk("t6_grant0", 32'({req0_ready, req1_ready}), 32'b10);
    push(1'b0, 8'h0F, 1'b0);
    wait_rsp(2, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_stable", 32'({rsp_valid, rsp_data, rsp_id, rsp_err}), 32'h1_0F_0_0 >> 0 == 0 ? 0 : {1'b1, 8'h0F, 1'b0, 1'b0});
      chk("t6_no_ready", 32'({req0_ready, req1_ready}), 0);
    end
    rsp_ready = 1;
    #1;
    chk("t6_no_ready_hs", 32'({req0_ready, req1_ready}), 0);
    step();
    chk("t6_grant1", 32'({rsp_valid, req0_ready, req1_ready}), 32'b001);
    push(1'b1, 8'h01, 1'b0);
    wait_rsp(2, 4'b1000);
    req0_valid = 0; req1_valid = 0;
    step();

    // Reset in the middle of a multiply
    req0_valid = 1; req0_sel = 4'b0101; req0_a = 4'h2; req0_b = 4'h3;
    #1;
    chk("t7_ready", 32'({req0_ready, req1_ready}), 32'b10);
    step();
    req0_valid = 0;
    step();
    chk("t7_in_exec", 32'({busy, rsp_valid}), 32'b10);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("t7_async");
    step();
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t7_no_rsp", 32'({busy, rsp_valid}), 0);
    end
    req0_valid = 1; req0_sel = 4'b0010; req0_a = 4'h4; req0_b = 4'h1;
    req1_valid = 1; req1_sel = 4'b0000; req1_a = 4'h1; req1_b = 4'h1;
    #1;
    chk("t7_grant0", 32'({req0_ready, req1_ready}), 32'b10);
    push(1'b0, 8'h05, 1'b0);
    wait_rsp(2, 4'b0010);
    req0_valid = 0; req1_valid = 0;
    step();
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
